// File: rtl/interpolate_and_fir_8bits_if.sv
// Sample-stream interface for the 2x interpolating half-band FIR.
interface interpolate_and_fir_8bits_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         single_valid_in;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         ready_out;
  logic                         iaf_valid_out;
  logic signed [DATA_WIDTH-1:0] iaf_data_out;
  logic                         overrun_out;

  modport master (
    output single_valid_in, data_in,
    input  ready_out, iaf_valid_out, iaf_data_out, overrun_out
  );

  modport slave (
    input  single_valid_in, data_in,
    output ready_out, iaf_valid_out, iaf_data_out, overrun_out
  );
endinterface

// File: rtl/interpolate_and_fir_8bits.sv
// Upsample-by-2 with a 16-tap half-band FIR as two serial 8-tap polyphase branches.
// Define INTERP_SATURATE_EN to saturate the phase B output instead of wrapping it.
module interpolate_and_fir_8bits #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  interpolate_and_fir_8bits_if.slave  iaf
);

  localparam int unsigned TAPS = 8;
  localparam int unsigned CW   = 10;
  localparam int unsigned PW   = DATA_WIDTH + CW;
  localparam int unsigned AW   = 20;

  localparam logic signed [AW-1:0] RND = AW'(128);
`ifdef INTERP_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = AW'(127);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-128);
`endif

  // Entries 0-7 are phase A, 8-15 are phase B; each branch sums to 256.
  localparam logic signed [CW-1:0] COEF_ROM [16] = '{
    10'sd0,   10'sd0,   10'sd0,    10'sd256,
    10'sd0,   10'sd0,   10'sd0,    10'sd0,
    -10'sd3,  10'sd6,   -10'sd14,  10'sd139,
    10'sd139, -10'sd14, 10'sd6,    -10'sd3
  };

  typedef enum logic [2:0] {IDLE, MAC_A, OUT_A, MAC_B, OUT_B} state_t;

  state_t                       state_q;
  logic signed [DATA_WIDTH-1:0] x_q [TAPS];
  logic signed [AW-1:0]         acc_q;
  logic [2:0]                   cnt_q;
  logic                         ready_q;
  logic                         valid_q;
  logic                         overrun_q;
  logic signed [DATA_WIDTH-1:0] data_q;

  logic                         accept;
  logic signed [CW-1:0]         coef;
  logic signed [PW-1:0]         prod;
  logic signed [AW-1:0]         acc_d;
  logic signed [AW-1:0]         shifted;
  logic signed [DATA_WIDTH-1:0] out_a;
  logic signed [DATA_WIDTH-1:0] out_b;

  // Datapath: one coefficient*tap product per cycle, plus rounding of the finished sum.
  always_comb begin
    accept  = iaf.single_valid_in && ready_q && (state_q == IDLE);
    coef    = COEF_ROM[{state_q == MAC_B, cnt_q}];
    prod    = PW'(coef) * PW'(x_q[cnt_q]);
    acc_d   = acc_q + AW'(prod);
    shifted = (acc_q + RND) >>> 8;
    out_a   = DATA_WIDTH'(shifted);
    out_b   = DATA_WIDTH'(shifted);
`ifdef INTERP_SATURATE_EN
    if (shifted > SAT_MAX) begin
      out_b = DATA_WIDTH'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      out_b = DATA_WIDTH'(SAT_MIN);
    end
`endif
  end

  // Ready lags the return to IDLE by one cycle, giving a 20-cycle frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
      for (int i = 0; i < int'(TAPS); i++) begin
        x_q[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      ready_q <= (state_q == IDLE) && !accept;
      if (iaf.single_valid_in && !ready_q) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_q[0] <= iaf.data_in;
            for (int i = 1; i < int'(TAPS); i++) begin
              x_q[i] <= x_q[i-1];
            end
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= MAC_A;
          end
        end
        MAC_A: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= OUT_A;
          end
        end
        OUT_A: begin
          data_q  <= out_a;
          valid_q <= 1'b1;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= MAC_B;
        end
        MAC_B: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= OUT_B;
          end
        end
        OUT_B: begin
          data_q  <= out_b;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign iaf.ready_out     = ready_q;
  assign iaf.iaf_valid_out = valid_q;
  assign iaf.iaf_data_out  = data_q;
  assign iaf.overrun_out   = overrun_q;

endmodule

// File: tb/tb_interpolate_and_fir_8bits.sv
// Directed bench for interpolate_and_fir_8bits: impulse, DC, overshoot, overrun, reset.
module tb_interpolate_and_fir_8bits;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  interpolate_and_fir_8bits_if #(.DATA_WIDTH(8)) iaf ();

  interpolate_and_fir_8bits #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .iaf (iaf)
  );

`ifdef INTERP_SATURATE_EN
  localparam logic signed [7:0] OS_B = 8'sd127;
`else
  localparam logic signed [7:0] OS_B = -8'sd95;
`endif

  logic signed [7:0] imp_a [8] = '{8'sd0, 8'sd0, 8'sd0, 8'sd100, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
  logic signed [7:0] imp_b [8] = '{-8'sd1, 8'sd2, -8'sd5, 8'sd54, 8'sd54, -8'sd5, 8'sd2, -8'sd1};
  logic signed [7:0] os_in [8] = '{-8'sd128, 8'sd127, -8'sd128, 8'sd127,
                                   8'sd127, -8'sd128, 8'sd127, -8'sd128};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Entered in a cycle where ready_out should be high; leaves in cycle 20 of the frame.
  task automatic frame(input logic signed [7:0] din, input logic signed [7:0] ea,
                       input logic signed [7:0] eb, input bit chk_data,
                       input int extra_at, input logic signed [7:0] extra_din,
                       input string tag);
    int                timing_bad;
    logic              va, vb;
    logic signed [7:0] ga, gb;
    timing_bad = 0;
    va = 1'b0; vb = 1'b0; ga = '0; gb = '0;
    chk($sformatf("%s_ready_c0", tag), 32'(iaf.ready_out), 1);
    iaf.single_valid_in = 1'b1;
    iaf.data_in         = din;
    tick();
    iaf.single_valid_in = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (iaf.ready_out) timing_bad++;
      if (iaf.iaf_valid_out && c != 10 && c != 19) timing_bad++;
      if (c == 10) begin va = iaf.iaf_valid_out; ga = iaf.iaf_data_out; end
      if (c == 19) begin vb = iaf.iaf_valid_out; gb = iaf.iaf_data_out; end
      if (c == extra_at) begin
        iaf.single_valid_in = 1'b1;
        iaf.data_in         = extra_din;
      end
      tick();
      iaf.single_valid_in = 1'b0;
    end
    chk($sformatf("%s_valid_c10", tag), 32'(va), 1);
    chk($sformatf("%s_valid_c19", tag), 32'(vb), 1);
    chk($sformatf("%s_timing", tag), 32'(timing_bad), 0);
    chk($sformatf("%s_ready_c20", tag), 32'(iaf.ready_out), 1);
    if (chk_data) begin
      chk($sformatf("%s_phase_a", tag), 32'(ga), 32'(ea));
      chk($sformatf("%s_phase_b", tag), 32'(gb), 32'(eb));
    end
  endtask

  initial begin
    int vcount;

    // Reset with a coincident strobe that must be ignored.
    rst                 = 1'b1;
    iaf.single_valid_in = 1'b1;
    iaf.data_in         = 8'sd77;
    tick();
    tick();
    chk("rst_ready", 32'(iaf.ready_out), 1);
    chk("rst_valid", 32'(iaf.iaf_valid_out), 0);
    chk("rst_data", 32'(iaf.iaf_data_out), 0);
    chk("rst_overrun", 32'(iaf.overrun_out), 0);
    iaf.single_valid_in = 1'b0;
    rst                 = 1'b0;
    tick();
    chk("post_rst_ready", 32'(iaf.ready_out), 1);
    chk("post_rst_overrun", 32'(iaf.overrun_out), 0);

    // Impulse response, back-to-back frames.
    for (int i = 0; i < 8; i++) begin
      frame((i == 0) ? 8'sd100 : 8'sd0, imp_a[i], imp_b[i], 1'b1, 0, 8'sd0,
            $sformatf("imp%0d", i));
    end
    chk("imp_no_overrun", 32'(iaf.overrun_out), 0);

    // DC gain at both rails.
    for (int i = 0; i < 8; i++) begin
      frame(8'sd127, 8'sd127, 8'sd127, (i == 7), 0, 8'sd0, $sformatf("dcp%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      frame(-8'sd128, -8'sd128, -8'sd128, (i == 7), 0, 8'sd0, $sformatf("dcn%0d", i));
    end

    // Overshoot: phase B exceeds the 8-bit range.
    for (int i = 0; i < 8; i++) begin
      frame(os_in[i], 8'sd127, OS_B, (i == 7), 0, 8'sd0, $sformatf("os%0d", i));
    end

    // Overrun: a strobe in cycle 5 is dropped without touching the delay line.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    frame(8'sd100, 8'sd0, -8'sd1, 1'b1, 5, 8'sd55, "ovr");
    chk("ovr_flag", 32'(iaf.overrun_out), 1);
    frame(8'sd0, 8'sd0, 8'sd2, 1'b1, 0, 8'sd0, "ovr_next");
    chk("ovr_sticky", 32'(iaf.overrun_out), 1);

    // Reset in cycle 14 of a frame aborts phase B and clears the delay line.
    iaf.single_valid_in = 1'b1;
    iaf.data_in         = 8'sd100;
    tick();
    iaf.single_valid_in = 1'b0;
    for (int c = 1; c < 14; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", 32'(iaf.ready_out), 1);
    chk("midrst_valid", 32'(iaf.iaf_valid_out), 0);
    chk("midrst_data", 32'(iaf.iaf_data_out), 0);
    chk("midrst_overrun", 32'(iaf.overrun_out), 0);
    vcount = 0;
    for (int c = 0; c < 10; c++) begin
      if (iaf.iaf_valid_out) vcount++;
      tick();
    end
    chk("midrst_no_strobe", 32'(vcount), 0);
    frame(8'sd50, 8'sd0, -8'sd1, 1'b1, 0, 8'sd0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interpolate_and_fir_8bits.md
INTERPOLATE_AND_FIR_8BITS -- requirements
Module: interpolate_and_fir_8bits

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, sample width in bits; only 8 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port single_valid_in  input  1  one-cycle strobe qualifying data_in.
REQ-005 SHALL have port data_in  input  signed 8  input sample at rate fs.
REQ-006 SHALL have port ready_out  output  1  high only in IDLE; strobes are accepted only while high.
REQ-007 SHALL have port iaf_valid_out  output  1  one-cycle strobe qualifying iaf_data_out.
REQ-008 SHALL have port iaf_data_out  output  signed 8  interpolated sample at rate 2*fs; held between strobes.
REQ-009 SHALL have port overrun_out  output  1  sticky flag: a strobe arrived while ready_out was low.

Function
REQ-010 SHALL implement upsample-by-2 with a 16-tap half-band FIR, split into two 8-tap polyphase branches over delay line x[n]..x[n-7].
REQ-011 Phase A coefficients (k=0..7) SHALL be 0,0,0,256,0,0,0,0, so phase A output equals x[n-3].
REQ-012 Phase B coefficients (k=0..7) SHALL be -3,6,-14,139,139,-14,6,-3, stored in a 16-entry ROM.
REQ-013 Each branch SHALL sum to 256, giving unity DC gain.
REQ-014 FSM states SHALL be IDLE, MAC_A, OUT_A, MAC_B, OUT_B.
REQ-015 FSM transitions: IDLE->MAC_A on an accepted strobe; MAC_A->OUT_A after 8 MAC cycles; OUT_A->MAC_B; MAC_B->OUT_B after 8 MAC cycles; OUT_B->IDLE.
REQ-016 On acceptance the delay line SHALL shift: data_in becomes x[n] and x[n-7] is discarded. The accumulator SHALL clear.
REQ-017 MAC SHALL perform one signed 8x10 product per cycle, k=0..7, into an accumulator of at least 18 bits signed (20 bits used).
REQ-018 Output value SHALL be (acc + 128) >>> 8, computed with an arithmetic shift.
REQ-019 Relative to the acceptance cycle 0: the phase A result SHALL appear with iaf_valid_out high in cycle 10, and the phase B result in cycle 19.
REQ-020 ready_out SHALL be low in cycles 1-19 and high again in cycle 20; a strobe in cycle 20 SHALL be accepted (throughput 1 input per 20 cycles).
REQ-021 iaf_valid_out SHALL be high for exactly one cycle per output. iaf_data_out SHALL hold its last value otherwise.
REQ-022 A strobe while ready_out is low SHALL be dropped without disturbing the delay line or the FSM, and SHALL set overrun_out.
REQ-023 A strobe coincident with OUT_B SHALL be dropped, because ready_out is low in that cycle.

Reset
REQ-024 While rst is high at a clock edge: state SHALL go to IDLE; delay line, accumulator, MAC counter, iaf_data_out, iaf_valid_out and overrun_out SHALL clear to 0.
REQ-025 ready_out SHALL be high in the first cycle after reset deasserts.
REQ-026 Reset asserted mid-operation SHALL abort the frame with no partial output strobe.
REQ-027 A strobe in the same cycle as rst high SHALL be ignored.

Configuration
REQ-028 With macro INTERP_SATURATE_EN defined, the shifted result SHALL saturate to [-128, 127].
REQ-029 Without INTERP_SATURATE_EN, the output SHALL be the low 8 bits of the shifted result (two's-complement wrap).
REQ-030 Phase A output is always within range, so the macro SHALL affect phase B only.

Verification
REQ-031 Impulse: inputs 100 then seven 0s, each strobe 20 cycles apart. Phase A outputs SHALL be 0,0,0,100,0,0,0,0. Phase B outputs SHALL be -1,2,-5,54,54,-5,2,-1.
REQ-032 DC: constant 127 for 8 inputs. After the 8th input both phases SHALL output 127. Repeat with -128: both SHALL output -128.
REQ-033 Overshoot: inputs -128,127,-128,127,127,-128,127,-128. The last phase B SHALL be 127 with INTERP_SATURATE_EN and -95 without; the last phase A SHALL be 127.
REQ-034 Overrun: strobe in cycle 0 and again in cycle 5. The second SHALL be dropped, overrun_out SHALL go high and stay high, and outputs SHALL match a single-input run. A strobe in cycle 20 SHALL be accepted.
REQ-035 Reset mid-frame: rst in cycle 14 after a 100 input. There SHALL be no phase B strobe, all outputs SHALL be 0, and ready_out SHALL be high in the next cycle. A following input of 50 SHALL yield phase A 0 (the delay line was cleared).
REQ-036 Timing: iaf_valid_out SHALL be high exactly in cycles 10 and 19 after acceptance, ready_out SHALL be low in cycles 1-19, and back-to-back strobes at 20-cycle spacing SHALL lose no sample.
